// File: rtl/zero_count_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : zc_pkg (package)
//  Purpose : Shared types and helpers for the serial zero counter:
//            FSM state encoding, a constant-evaluable clog2 and a plain
//            reference zero-count function.
//  Revision: 1.0  initial release
// ============================================================================
package zc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } zc_state_t;

    // Ceiling log2; usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Number of zero bits in the low 'width' bits of 'word'.
    function automatic int countzeros(input logic [63:0] word, input int width);
        int zeros;
        zeros = 0;
        for (int i = 0; i < width; i++) begin
            if (!word[i]) zeros = zeros + 1;
        end
        return zeros;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zero_count_serial_if.sv
`default_nettype none
// ============================================================================
//  Module  : zero_count_serial_if
//  Purpose : Valid/ready word input and valid/ready count output of the
//            serial zero counter.
//  Ports   : in_valid/in_ready/in_data   word channel (source -> counter)
//            out_valid/out_ready/out_count result channel (counter -> sink)
//  Modports: master = word source / result sink, slave = counter
//  Revision: 1.0  initial release
// ============================================================================
interface zero_count_serial_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface
`default_nettype wire

// File: rtl/zero_count_serial_sat_acc.sv
`default_nettype none
// ============================================================================
//  Module  : zc_sat_acc
//  Purpose : Saturating running total. Adds add_val when add_en is high;
//            clear forces zero and takes priority over an add in the same
//            cycle. Once saturated the total stays at all-ones until clear.
//  Ports   : clk, rst (async, active-high), clear (sync), add_en,
//            add_val[CNT_W], total[TOT_W]
//  Revision: 1.0  initial release
// ============================================================================
module zc_sat_acc #(
    parameter int TOT_W = 16,
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             add_en,
    input  wire logic [CNT_W-1:0] add_val,
    output logic      [TOT_W-1:0] total
);

    logic [TOT_W-1:0] r_total;
    logic [TOT_W:0]   w_sum;

    // One extra bit catches the carry that signals overflow.
    always_comb begin
        w_sum = {1'b0, r_total} + (TOT_W+1)'(add_val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total <= '0;
        end else if (clear) begin
            r_total <= '0;
        end else if (add_en) begin
            r_total <= w_sum[TOT_W] ? {TOT_W{1'b1}} : w_sum[TOT_W-1:0];
        end
    end

    assign total = r_total;

endmodule
`default_nettype wire

// File: rtl/zero_count_serial.sv
`default_nettype none
// ============================================================================
//  Module  : zero_count_serial
//  Purpose : Accepts one DATA_W-bit word, examines it one bit per clock and
//            presents its zero-bit count on a valid/ready output. Keeps a
//            saturating running total of all consumed counts.
//  Ports   : clk        clock, rising edge
//            rst        asynchronous active-high reset
//            bus        slave side of zero_count_serial_if (word in, count out)
//            clear      synchronous clear of total (wins over an add)
//            total      saturating sum of consumed counts
//            busy       high while shifting or holding a result
//  Revision: 1.0  initial release
// ============================================================================
module zero_count_serial
    import zc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int TOT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    zero_count_serial_if.slave    bus,
    input  wire logic             clear,
    output logic      [TOT_W-1:0] total,
    output logic                  busy
);

    localparam int BIT_W = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);

    if (CNT_W < clog2(DATA_W + 1)) begin : g_cnt_w_check
        $error("zero_count_serial: CNT_W too small to hold a count of DATA_W");
    end

    zc_state_t         r_state;
    zc_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [BIT_W-1:0]  r_bitcnt;
    logic [CNT_W-1:0]  r_cnt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_busy;
    logic w_accept;
    logic w_out_fire;
    logic w_last_bit;

    assign w_accept   = w_in_ready & bus.in_valid;
    assign w_out_fire = w_out_valid & bus.out_ready;
    assign w_last_bit = (r_bitcnt == BIT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_last_bit) w_state_nxt = DONE;
            end
            DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load on acceptance, then consume LSB-first, one bit per cycle.
    // In DONE nothing changes, so the count stays stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_shreg  <= bus.in_data;
            r_bitcnt <= '0;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, ~r_shreg[0]};
            r_shreg  <= r_shreg >> 1;
            r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    zc_sat_acc #(
        .TOT_W (TOT_W),
        .CNT_W (CNT_W)
    ) u_sat_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .add_en  (w_out_fire),
        .add_val (r_cnt),
        .total   (total)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_count = r_cnt;
    assign busy          = w_busy;

endmodule
`default_nettype wire
